// File: rtl/peripheral_uart_rx.sv
// J1 UART receive peripheral: 16x-oversampled 8N1 deserializer feeding a small
// byte FIFO, read through DATA/STATUS registers and cleared through CLEAR.
module peripheral_uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  input  logic        uart_rx
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW      = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI} state_t;

  state_t         state, state_n;
  logic [1:0]     sync;
  logic           rx_s;
  logic [PW-1:0]  ps;
  logic           tick;
  logic [3:0]     tc;
  logic [2:0]     bi;
  logic [7:0]     sh;
  logic           ps_clr, tc_clr, bit_smp, push, ferr_set;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wp, rp;
  logic [CW-1:0]  count;
  logic           overrun, frame_err;
  logic           avail, full, pop, push_ok, ovr_set, clr;
  logic [2:0]     cnt3;
  logic           unused_ok;

  assign unused_ok = ^d_in;
  assign rx_s      = sync[1];
  assign tick      = (ps == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], uart_rx};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    ps_clr   = 1'b0;
    tc_clr   = 1'b0;
    bit_smp  = 1'b0;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      S_IDLE: if (!rx_s) begin
        ps_clr  = 1'b1;
        tc_clr  = 1'b1;
        state_n = S_START;
      end
      S_START: if (tick && tc == 4'd7) begin
        tc_clr  = 1'b1;
        state_n = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (tick && tc == 4'd15) begin
        bit_smp = 1'b1;
        if (bi == 3'd7) state_n = S_STOP;
      end
      S_STOP: if (tick && tc == 4'd15) begin
        if (rx_s) begin
          push    = 1'b1;
          state_n = S_IDLE;
        end else begin
          ferr_set = 1'b1;
          state_n  = S_WAIT_HI;
        end
      end
      S_WAIT_HI: if (rx_s) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // tc wraps 15->0 on its own, so each data bit restarts its 16-tick window
  always_ff @(posedge clk) begin
    if (rst) begin
      ps <= '0;
      tc <= '0;
      bi <= '0;
      sh <= '0;
    end else begin
      if (ps_clr || tick) ps <= '0;
      else                ps <= ps + PW'(1);
      if (tc_clr)    tc <= '0;
      else if (tick) tc <= tc + 4'd1;
      if (state == S_START) bi <= '0;
      else if (bit_smp)     bi <= bi + 3'd1;
      if (bit_smp) sh[bi] <= rx_s;
    end
  end

  assign avail   = (count != '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = cs && rd && addr == 4'h0 && avail;
  assign push_ok = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign clr     = cs && wr && addr == 4'h4;
  assign cnt3    = 3'(count);

  // when full, wp == rp, so a same-cycle push overwrites the slot being popped
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop)     rp <= rp + AW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
      if (ovr_set)  overrun <= 1'b1;
      else if (clr) overrun <= 1'b0;
      if (ferr_set) frame_err <= 1'b1;
      else if (clr) frame_err <= 1'b0;
    end
  end

  always_comb begin
    d_out = 16'h0000;
    if (cs) begin
      case (addr)
        4'h0:    d_out = avail ? {8'h00, mem[rp]} : 16'h0000;
        4'h2:    d_out = {9'b0, cnt3, overrun, frame_err, full, avail};
        default: d_out = 16'h0000;
      endcase
    end
  end

endmodule

// File: doc/peripheral_uart_rx.md
# peripheral_uart_rx

UART receive peripheral for the J1 SoC, the counterpart of the existing UART transmit peripheral. It deserializes 8N1 frames from the `uart_rx` pin using 16x oversampling and buffers received bytes in a small FIFO. Software reads the bytes through the standard J1 I/O peripheral bus. The SoC address decoder maps it at base 16'h6A00 with its own chip-select line.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate. `DIV` = CLK_FREQ/(BAUD*16), integer-truncated, minimum 1.
- `FIFO_DEPTH`, 4: receive FIFO entries; must be a power of 2.

Ports:
- `clk`  in  1: system clock. The block uses this single clock.
- `rst`  in  1: reset, synchronous and active-high.
- `d_in`  in  16: J1 write data.
- `cs`  in  1: chip-select from the SoC decoder.
- `addr`  in  4: register offset, `j1_io_addr[3:0]`.
- `rd`  in  1: read strobe, one cycle per access.
- `wr`  in  1: write strobe, one cycle per access.
- `d_out`  out  16: read data.
- `uart_rx`  in  1: serial input, asynchronous, idles high.

## Operation
Register map (an access requires `cs`=1):
- 4'h0 DATA (read): `d_out` = {8'h00, FIFO head}. On a rd strobe the head entry is popped. If the FIFO is empty, `d_out` = 16'h0000 and no state changes.
- 4'h2 STATUS (read): `d_out` = {9'b0, count[2:0], overrun, frame_err, full, avail}. Reading STATUS has no side effects.
- 4'h4 CLEAR (write): any `d_in` clears `frame_err` and `overrun`. FIFO contents are unaffected.
- Other offsets read 16'h0000; writes to other offsets are ignored.
- When `cs`=0, `d_out` = 16'h0000.

Input path: `uart_rx` passes through a 2-flop synchronizer to give `rx_s`. Only `rx_s` is used internally.

Prescaler: counts 0..DIV-1 and emits a one-cycle `tick` on the terminal count. It is reset to 0 on start-edge detection so that sampling aligns with the frame.

FSM, with a 4-bit tick counter `tc` and a 3-bit bit index `bi`:
- IDLE: on `rx_s`=0, clear the prescaler and `tc`, then go to START.
- START: on the 8th tick (mid start bit), if `rx_s`=0 go to DATA with `tc`=0 and `bi`=0. Otherwise the start is treated as a glitch and the FSM returns to IDLE.
- DATA: every 16th tick, sample `rx_s` into shift-register bit `bi` (LSB first). After `bi`=7 is sampled, go to STOP.
- STOP: on the 16th tick, sample the stop bit.
  - If `rx_s`=1: push the byte and go to IDLE.
  - If `rx_s`=0: set `frame_err`, discard the byte, and go to WAIT_HI.
- WAIT_HI: stay until `rx_s`=1, then go to IDLE. This absorbs a break condition.

FIFO and flags:
- A push when the FIFO is full drops the new byte, sets `overrun`, and leaves the contents unchanged.
- A push and a pop in the same cycle both take effect, so `count` is unchanged. When the FIFO is full, a same-cycle push and pop succeeds with no overrun.
- `avail` = (count != 0). `full` = (count == FIFO_DEPTH).
- The pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth. `count` is log2(FIFO_DEPTH)+1 bits.
- If a flag set and a CLEAR write occur in the same cycle, the set wins.

## Timing
- Reset (synchronous, `rst`=1 at a clock edge):
  - FSM → IDLE; `tc`, `bi`, the prescaler, pointers and `count` are all 0.
  - `frame_err` = `overrun` = 0.
  - Synchronizer flops preset to 1.
  - `d_out` = 16'h0000 (it is combinational with `cs`=0).
- Reset asserted mid-frame abandons the frame with no push and no flag change. The next start edge after reset is received normally.
- `d_out` is combinational from `cs`, `addr` and FIFO/status state, and is valid in the same cycle as `rd`. The pop and pointer update happen on the clock edge that ends the `rd` cycle.
- Latency from the `uart_rx` falling edge to `avail`=1 is 2 sync cycles + (8+8·16+16)·DIV clocks + 1 clock, approximately 9.5 bit times.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so the next start edge is detected with no lost frame.

## Test plan
Bench parameters are CLK_FREQ=6_400_000 and BAUD=100_000, which give DIV=4 and 64 clocks per bit.
- Single frame 8'hA5 (sent LSB first as 1,0,1,0,0,1,0,1) → STATUS reads 16'h0011. DATA then reads 16'h00A5, after which STATUS reads 16'h0000.
- Glitch: `uart_rx` low for 16 clocks, then high → no push, FSM back in IDLE, STATUS 16'h0000.
- Frame 8'h3C with stop bit = 0, line held low for 200 clocks and then released → `frame_err`=1, count=0. A CLEAR write with 16'h0000 gives STATUS 16'h0000. A following good frame 8'h55 is received correctly.
- Five back-to-back frames 8'h01..8'h05 with no reads:
  - STATUS = 16'h0043 (count=4, full=1, avail=1, overrun=0) before the fifth frame's stop bit, and 16'h004B (overrun set) after it.
  - Reads return 01, 02, 03, 04; byte 05 is lost.
- Simultaneous push and pop: with the FIFO full, issue a DATA read exactly in the stop-bit push cycle → count stays 4, no overrun, and the new byte is in the last position.
- Assert `rst` for 1 cycle during DATA bit 3 of a frame → no push, all flags 0. The next frame 8'hFF is received correctly.
